// File: rtl/restador_serie_pkg.sv
// Shared definitions for the bit-serial ALU units.
// Contents:
//   state_e   - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width - width of a bit counter that indexes 0..w-1 (at least 1 bit)
package restador_serie_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/restador_completo.sv
// Combinational 1-bit full subtractor: computes a - b - bin.
// Ports:
//   a, b  - operand bits
//   bin   - borrow in
//   d     - difference bit
//   bout  - borrow out
module restador_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they tie and a borrow is pending.
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/restador_serie.sv
// Bit-serial subtractor: diff = A - B, one bit per clock, LSB first.
// A start/done handshake lets a controller issue operations back to back.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   start       - request; operands sampled when the block accepts it (IDLE or DONE)
//   A, B        - minuend and subtrahend
//   busy        - high while the operation runs
//   done        - one-cycle pulse when diff/bout/ovf have just been updated
//   diff        - A - B mod 2^WIDTH
//   bout        - final borrow (A < B unsigned)
//   ovf         - signed overflow of the subtraction
module restador_serie
  import restador_serie_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             bit_d, bit_bout;

  restador_completo u_completo (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          br_d    = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {bit_d, res_q[WIDTH-1:1]};
        br_d  = bit_bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cnt_d   = '0;
          diff_d  = {bit_d, res_q[WIDTH-1:1]};
          bout_d  = bit_bout;
          // On the last bit a_q[0]/b_q[0] are the original sign bits.
          ovf_d   = (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    diff = diff_q;
    bout = bout_q;
    ovf  = ovf_q;
  end

endmodule
